// File: rtl/shift_sequencer.sv
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-cycle shift controller. It iterates a single-position 32-bit
//            logical shifter cell once per clock to shift by 0-31 positions.
//            Optional macro SHIFT_SEQ_ROTATE_EN adds the rotate port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  amt,
    input  logic              dir,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic              rotate,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    localparam logic [AMT_W-1:0] c_cnt_one = AMT_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [AMT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_sreg;
    logic              r_dir;
    logic [DATA_W-1:0] w_cell_s;
    logic [DATA_W-1:0] w_sreg_nxt;

    // Single-position shifter cell: C=1 left, C=0 right, vacated bit is 0.
    assign w_cell_s = r_dir ? {r_sreg[DATA_W-2:0], 1'b0}
                            : {1'b0, r_sreg[DATA_W-1:1]};

`ifdef SHIFT_SEQ_ROTATE_EN
    logic r_rot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rot <= 1'b0;
        end else if (r_state == c_idle && start) begin
            r_rot <= rotate;
        end
    end

    // Rotation feeds the evicted bit back into the freshly vacated position.
    always_comb begin
        w_sreg_nxt = w_cell_s;
        if (r_rot) begin
            if (r_dir) begin
                w_sreg_nxt[0] = w_cell_s[0] | r_sreg[DATA_W-1];
            end else begin
                w_sreg_nxt[DATA_W-1] = w_cell_s[DATA_W-1] | r_sreg[0];
            end
        end
    end
`else
    assign w_sreg_nxt = w_cell_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_state_nxt = (amt == '0) ? c_done : c_shift;
                end
            end
            c_shift: begin
                if (r_cnt == c_cnt_one) begin
                    w_state_nxt = c_done;
                end
            end
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        busy = (r_state != c_idle);
        done = (r_state == c_done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_sreg <= data_in;
                        r_cnt  <= amt;
                        r_dir  <= dir;
                    end
                end
                c_shift: begin
                    r_sreg <= w_sreg_nxt;
                    r_cnt  <= r_cnt - c_cnt_one;
                end
                default: ;
            endcase
        end
    end

    assign result = r_sreg;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer (table vectors plus
//            hand-written reset, held-start, abort and rotate sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  amt;
    logic        dir;
    logic        rotate;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks;
    int n_fail;

    shift_sequencer #(.DATA_W(32), .AMT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .amt     (amt),
        .dir     (dir),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rotate  (rotate),
`endif
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  amt;
        logic        dir;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one operation from IDLE and checks latency, result and handshake.
    task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] a,
                          input logic dr, input logic rot, input logic [31:0] exp);
        int n;
        start   = 1'b1;
        data_in = d;
        amt     = a;
        dir     = dr;
        rotate  = rot;
        tick();
        start   = 1'b0;
        data_in = ~d;
        amt     = ~a;
        dir     = ~dr;
        rotate  = ~rot;
        check({name, " busy_rise"}, {31'd0, busy}, 32'd1);
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, a + 1);
        check({name, " result"}, result, exp);
        tick();
        check({name, " done_pulse"}, {31'd0, done}, 32'd0);
        check({name, " busy_fall"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b1;
        data_in  = 32'hFFFF_FFFF;
        amt      = 5'd3;
        dir      = 1'b1;
        rotate   = 1'b0;

        vecs[0] = '{32'h0000_0001, 5'd4,  1'b1, 32'h0000_0010};
        vecs[1] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
        vecs[2] = '{32'h8000_0000, 5'd31, 1'b1, 32'h0000_0000};
        vecs[3] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{32'h0000_FFFF, 5'd8,  1'b1, 32'h00FF_FF00};
        vecs[5] = '{32'hF000_0000, 5'd4,  1'b0, 32'h0F00_0000};
        vecs[6] = '{32'h1234_5678, 5'd16, 1'b0, 32'h0000_1234};
        vecs[7] = '{32'h1234_5678, 5'd1,  1'b1, 32'h2468_ACF0};
        vecs[8] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001};
        vecs[9] = '{32'hA5A5_A5A5, 5'd3,  1'b0, 32'h14B4_B4B4};

        // Reset with start held high must leave the block idle.
        tick();
        tick();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("post-reset busy", {31'd0, busy}, 32'd0);
        check("post-reset result", result, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].dir, 1'b0, vecs[i].exp);
        end

        // Start held through DONE: next accept only after returning to IDLE.
        start   = 1'b1;
        data_in = 32'hDEAD_BEEF;
        amt     = 5'd0;
        dir     = 1'b0;
        tick();
        data_in = 32'h1234_5678;
        check("held done", {31'd0, done}, 32'd1);
        check("held result1", result, 32'hDEAD_BEEF);
        tick();
        check("held idle busy", {31'd0, busy}, 32'd0);
        check("held idle result", result, 32'hDEAD_BEEF);
        tick();
        start = 1'b0;
        check("held reaccept done", {31'd0, done}, 32'd1);
        check("held result2", result, 32'h1234_5678);
        tick();
        check("held end busy", {31'd0, busy}, 32'd0);

        // Abort on the 3rd SHIFT cycle of an amt=10 op.
        start   = 1'b1;
        data_in = 32'h0000_00FF;
        amt     = 5'd10;
        dir     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort mid busy", {31'd0, busy}, 32'd1);
        check("abort mid result", result, 32'h0000_03FC);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort result", result, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (done) seen++;
            end
            check("abort no done", seen, 0);
        end
        run_op("after abort", 32'h0000_00FF, 5'd10, 1'b1, 1'b0, 32'h0003_FC00);

`ifdef SHIFT_SEQ_ROTATE_EN
        run_op("rot left", 32'h8000_0001, 5'd1, 1'b1, 1'b1, 32'h0000_0003);
        run_op("norot left", 32'h8000_0001, 5'd1, 1'b1, 1'b0, 32'h0000_0002);
        run_op("rot right", 32'h0000_0001, 5'd4, 1'b0, 1'b1, 32'h1000_0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
